// File: rtl/wb_timer.sv
// wb_timer: Wishbone machine timer (mtime/mtimecmp) with prescaler and level interrupt
module wb_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  input  logic [31:0] idat_i,
  input  logic [3:0]  isel_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  input  logic        iwe_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  output logic        xint
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t                r_state;
  logic [63:0]           r_mtime, r_mtimecmp;
  logic [1:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_presc, r_cnt;
  logic [31:0]           r_dat;
  logic                  r_ack, r_err, r_xint;
  logic                  w_hit, w_req, w_err, w_wr, w_tick;
  logic [2:0]            w_idx;
  logic [31:0]           w_mask, w_rdat, w_wdat;
  logic [63:0]           w_mtime_nx;
  assign w_hit  = iaddr_i[31:5] == BASE_ADDR[31:5];
  assign w_req  = (r_state == IDLE) && icyc_i && istb_i && w_hit;
  assign w_idx  = iaddr_i[4:2];
  assign w_err  = (|iaddr_i[1:0]) || (w_idx > 3'd5) || (isel_i == 4'd0);
  assign w_wr   = w_req && iwe_i && !w_err;
  assign w_mask = {{8{isel_i[3]}}, {8{isel_i[2]}}, {8{isel_i[1]}}, {8{isel_i[0]}}};
  assign w_wdat = (w_rdat & ~w_mask) | (idat_i & w_mask);
  assign w_tick = r_ctrl[0] && (r_cnt == r_presc);
  // a bus write to either mtime half replaces the tick for that cycle
  assign w_mtime_nx = (w_wr && w_idx == 3'd0) ? {r_mtime[63:32], w_wdat} :
                      (w_wr && w_idx == 3'd1) ? {w_wdat, r_mtime[31:0]} :
                      r_mtime + 64'(w_tick);
  always_comb begin
    case (w_idx)
      3'd0:    w_rdat = r_mtime[31:0];
      3'd1:    w_rdat = r_mtime[63:32];
      3'd2:    w_rdat = r_mtimecmp[31:0];
      3'd3:    w_rdat = r_mtimecmp[63:32];
      3'd4:    w_rdat = {30'd0, r_ctrl};
      3'd5:    w_rdat = 32'(r_presc);
      default: w_rdat = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ctrl     <= '0;
      r_presc    <= '0;
      r_cnt      <= '0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_xint     <= 1'b0;
    end else begin
      r_state <= w_req ? RESP : IDLE;
      r_ack   <= w_req && !w_err;
      r_err   <= w_req && w_err;
      r_dat   <= (w_req && !w_err) ? w_rdat : '0;
      r_mtime <= w_mtime_nx;
      r_xint  <= r_ctrl[1] && (r_mtime >= r_mtimecmp);
      if (r_ctrl[0]) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_wr && w_idx == 3'd2) r_mtimecmp[31:0]  <= w_wdat;
      if (w_wr && w_idx == 3'd3) r_mtimecmp[63:32] <= w_wdat;
      if (w_wr && w_idx == 3'd4) r_ctrl <= w_wdat[1:0];
      if (w_wr && w_idx == 3'd5) r_presc <= PRESCALE_W'(w_wdat);
    end
  end
  assign idat_o = r_dat;
  assign iack_o = r_ack;
  assign ierr_o = r_err;
  assign xint   = r_xint;
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: randomized scoreboard bench for wb_timer against an arithmetic timer model
module tb_wb_timer;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] iaddr = '0, idat = '0;
  logic [3:0]  isel = '0;
  logic        icyc = 1'b0, istb = 1'b0, iwe = 1'b0;
  logic [31:0] idat_o;
  logic        iack_o, ierr_o, xint;
  wb_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .iaddr_i(iaddr), .idat_i(idat), .isel_i(isel),
    .icyc_i(icyc), .istb_i(istb), .iwe_i(iwe), .idat_o(idat_o),
    .iack_o(iack_o), .ierr_o(ierr_o), .xint(xint)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0, nresp = 0, last_r = 0;
  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
    int          at;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  // model: mtime is m_base at edge m_e, then +1 every (m_p+1) edges while enabled
  logic [63:0] m_base, m_cmp;
  int          m_e;
  logic [15:0] m_p;
  logic [1:0]  m_ctrl;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
    end
  endtask
  function automatic logic [63:0] mt(input int r);
    return m_ctrl[0] ? m_base + 64'((r - 1 - m_e) / (int'(m_p) + 1)) : m_base;
  endfunction
  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  function automatic logic [31:0] mread(input logic [2:0] idx, input int r);
    logic [63:0] t;
    t = mt(r);
    case (idx)
      3'd0:    return t[31:0];
      3'd1:    return t[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {30'd0, m_ctrl};
      default: return {16'd0, m_p};
    endcase
  endfunction
  task automatic mwrite(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s, input int r);
    logic [31:0] mk;
    logic [63:0] t;
    logic [1:0]  nc;
    mk = lanes(s);
    case (idx)
      3'd0, 3'd1: begin
        t = mt(r);
        if (idx == 3'd0) t[31:0] = (t[31:0] & ~mk) | (d & mk);
        else t[63:32] = (t[63:32] & ~mk) | (d & mk);
        m_base = t;
        m_e = r;
      end
      3'd2: m_cmp[31:0] = (m_cmp[31:0] & ~mk) | (d & mk);
      3'd3: m_cmp[63:32] = (m_cmp[63:32] & ~mk) | (d & mk);
      3'd4: begin
        nc = s[0] ? d[1:0] : m_ctrl;
        if (nc[0] && !m_ctrl[0]) m_e = r;
        if (!nc[0] && m_ctrl[0]) m_base = mt(r + 1);
        m_ctrl = nc;
      end
      default: m_p = 16'(({16'd0, m_p} & ~mk) | (d & mk));
    endcase
  endtask
  task automatic model_reset();
    m_base = '0; m_cmp = '1; m_e = 0; m_p = '0; m_ctrl = '0;
    exp_q.delete();
  endtask
  always @(negedge clk) begin
    if (iack_o || ierr_o) begin
      nresp++;
      check("single_pulse", 64'(mon_prev), 64'(0));
      if (exp_q.size() == 0) check("unexpected_resp", 64'(1), 64'(0));
      else begin
        mon_e = exp_q.pop_front();
        check("err_flag", 64'(ierr_o), 64'(mon_e.err));
        check("ack_flag", 64'(iack_o), 64'(!mon_e.err));
        check("latency", 64'(cyc), 64'(mon_e.at));
        if (mon_e.err) check("err_dat", 64'(idat_o), 64'(0));
        if (mon_e.chk) check("rdata", 64'(idat_o), 64'(mon_e.dat));
      end
    end else check("idle_dat", 64'(idat_o), 64'(0));
    mon_prev = iack_o || ierr_o;
  end
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    logic hit;
    logic [2:0] idx;
    int n0;
    @(posedge clk); #1;
    iaddr = a; idat = d; isel = s; iwe = we; icyc = 1'b1; istb = 1'b1;
    e.at = cyc + 1;
    last_r = e.at;
    idx = a[4:2];
    hit = a[31:5] == BASE[31:5];
    e.err = (a[1:0] != 2'd0) || (idx > 3'd5) || (s == 4'd0);
    e.chk = !we && !e.err;
    e.dat = e.err ? 32'd0 : mread(idx, e.at);
    n0 = nresp;
    if (hit) begin
      exp_q.push_back(e);
      if (we && !e.err) mwrite(idx, d, s, e.at);
    end
    @(posedge clk); #1;
    icyc = 1'b0; istb = 1'b0; iwe = 1'b0;
    if (hit) begin
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
        @(negedge clk); #1;
      end
      if (exp_q.size() > 0) begin
        check("resp_timeout", 64'(1), 64'(0));
        exp_q.delete();
      end
    end else begin
      repeat (5) @(negedge clk);
      #1 check("nohit_silent", 64'(nresp), 64'(n0));
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(iack_o), 64'(0));
    check("rst_err", 64'(ierr_o), 64'(0));
    check("rst_xint", 64'(xint), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p, w, e_edge, rise, n0, k;
    logic [2:0] idx;
    logic [31:0] a, d;
    logic [3:0] s;
    logic we;
    model_reset();
    do_reset();
    xfer(0, BASE + 32'h08, 0, 4'hF);
    xfer(0, BASE + 32'h0C, 0, 4'hF);
    xfer(0, BASE + 32'h00, 0, 4'hF);
    for (int it = 0; it < 3; it++) begin
      do_reset();
      p = (it == 0) ? 3 : int'($urandom_range(0, 7));
      w = (it == 0) ? 40 : int'($urandom_range(5, 60));
      xfer(1, BASE + 32'h14, 32'(p), 4'hF);
      xfer(1, BASE + 32'h10, 32'h1, 4'hF);
      repeat (w) @(posedge clk);
      xfer(0, BASE + 32'h00, 0, 4'hF);
      xfer(0, BASE + 32'h04, 0, 4'hF);
    end
    do_reset();
    xfer(1, BASE + 32'h00, 32'hFFFF_FFFE, 4'hF);
    xfer(1, BASE + 32'h04, 32'h0, 4'hF);
    xfer(1, BASE + 32'h10, 32'h1, 4'hF);
    xfer(1, BASE + 32'h10, 32'h0, 4'hF);
    xfer(0, BASE + 32'h04, 0, 4'hF);
    xfer(0, BASE + 32'h00, 0, 4'hF);
    check("carry_hi", 64'(mt(cyc + 1) >> 32), 64'(1));
    do_reset();
    xfer(1, BASE + 32'h08, 32'd100, 4'hF);
    xfer(1, BASE + 32'h0C, 32'd0, 4'hF);
    xfer(1, BASE + 32'h00, 32'd90, 4'hF);
    xfer(1, BASE + 32'h10, 32'h3, 4'hF);
    e_edge = last_r;
    rise = -1;
    for (int i = 0; i < 40 && rise < 0; i++) begin
      @(negedge clk);
      if (xint) rise = cyc;
    end
    check("xint_rise", 64'(rise >= e_edge + 10 && rise <= e_edge + 12), 64'(1));
    xfer(1, BASE + 32'h0C, 32'h1, 4'hF);
    @(posedge clk); @(negedge clk);
    check("xint_clear", 64'(xint), 64'(0));
    do_reset();
    xfer(0, BASE + 32'h18, 0, 4'hF);
    xfer(1, BASE + 32'h02, 32'h1234_5678, 4'hF);
    xfer(1, BASE + 32'h0C, 32'h0, 4'h0);
    xfer(1, BASE + 32'h1C, 32'h1, 4'hF);
    xfer(0, BASE + 32'h00, 0, 4'hF);
    xfer(0, BASE + 32'h0C, 0, 4'hF);
    xfer(0, BASE + 32'h40, 0, 4'hF);
    xfer(1, BASE + 32'h08, 32'hAABB_CCDD, 4'b0010);
    xfer(0, BASE + 32'h08, 0, 4'hF);
    check("lane_model", 64'(m_cmp[31:0]), 64'(32'hFFFF_CCFF));
    xfer(1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    xfer(0, BASE + 32'h14, 0, 4'hF);
    xfer(1, BASE + 32'h14, 32'h0, 4'hF);
    xfer(1, BASE + 32'h10, 32'h1, 4'hF);
    repeat ($urandom_range(3, 20)) @(posedge clk);
    xfer(1, BASE + 32'h00, 32'd5, 4'hF);
    xfer(0, BASE + 32'h00, 0, 4'hF);
    xfer(1, BASE + 32'h10, 32'h0, 4'hF);
    xfer(0, BASE + 32'h00, 0, 4'hF);
    xfer(1, BASE + 32'h08, 32'h1234, 4'hF);
    @(posedge clk); #1;
    iaddr = BASE + 32'h08; isel = 4'hF; iwe = 1'b0; icyc = 1'b1; istb = 1'b1; rst = 1'b1;
    n0 = nresp;
    @(posedge clk); #1;
    icyc = 1'b0; istb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_drop_resp", 64'(nresp), 64'(n0));
    xfer(0, BASE + 32'h08, 0, 4'hF);
    for (int it = 0; it < 40; it++) begin
      k = int'($urandom_range(0, 9));
      idx = 3'($urandom_range(0, 7));
      a = BASE + {27'd0, idx, 2'b00};
      if (k == 7) a = a + 32'($urandom_range(1, 3));
      if (k >= 8) a = BASE + 32'h20 * 32'($urandom_range(1, 8)) + {27'd0, idx, 2'b00};
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      if (idx == 3'd4) d[0] = 1'b0;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      xfer(we, a, d, s);
      @(posedge clk); @(negedge clk);
      check("xint_level", 64'(xint), 64'(m_ctrl[1] && (mt(cyc) >= m_cmp)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone responder implementing a RISC-V style machine timer (mtime/mtimecmp) for the load_store_unit data bus.
- Sits beside bram on the same bus signals and decodes its own address window.
- Drives the xint input of load_store_unit when the timer is enabled and mtime >= mtimecmp.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 32-byte register window.
- PRESCALE_W, 16, width of the prescaler register and counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- iaddr_i  in  32  byte address from the initiator.
- idat_i  in  32  write data.
- isel_i  in  4  byte lane enables; bit n selects bits [8n+7:8n].
- icyc_i  in  1  bus cycle valid.
- istb_i  in  1  strobe / request valid.
- iwe_i  in  1  1 = write, 0 = read.
- idat_o  out  32  read data, valid only while iack_o is 1.
- iack_o  out  1  normal termination, one-cycle pulse.
- ierr_o  out  1  error termination, one-cycle pulse.
- xint  out  1  timer interrupt, level.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: idat_o=0, iack_o=0, ierr_o=0, xint=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, prescale=0, prescale counter=0, FSM=IDLE.
- Register map (offset from BASE_ADDR):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 ctrl: bit0 = enable, bit1 = irq_en, bits[31:2] read 0 and ignore writes.
  - 0x14 prescale, zero-extended to 32 bits on read.
  - 0x18 and 0x1C are unmapped.
- Address decode: hit when iaddr_i[31:5] == BASE_ADDR[31:5].
- Error conditions: iaddr_i[1:0] != 0, an unmapped offset, or isel_i == 0 inside the window each produce ierr_o instead of iack_o.
- No decode hit: no response at all; iack_o and ierr_o stay 0.
- FSM states IDLE and RESP:
  - IDLE -> RESP on icyc_i & istb_i & hit. In that same edge the write is performed (if legal) and read data is latched.
  - RESP drives exactly one cycle of iack_o or ierr_o, then returns to IDLE unconditionally.
  - Latency: request sampled at edge N, response visible in cycle N+1.
  - In RESP the strobe is ignored. A request still held in the following IDLE cycle is treated as a new request, so back-to-back transfers run at one transfer per two cycles.
  - icyc_i dropping while in RESP does not cancel the pulse.
- Writes: per-byte merge using isel_i. For prescale, lanes beyond PRESCALE_W are ignored. Errored writes change nothing.
- Read data: idat_o is 0 outside RESP and 0 on ierr_o.
- Counting, when ctrl.enable=1:
  - The prescale counter increments each cycle.
  - When counter == prescale, the counter clears and mtime increments by 1 (64-bit, carry from low word into high word).
  - prescale=0 means mtime increments every cycle.
  - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
  - When enable=0, mtime and the counter hold.
- Simultaneous bus write and increment on mtime: the bus write wins on written lanes. Unwritten lanes keep their pre-increment value and the increment is dropped for that cycle.
- Interrupt: xint is registered as ctrl.irq_en & (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the current register values. Latency is 1 cycle after the condition becomes true. Writing mtimecmp above mtime clears xint on the next cycle.
- Reset asserted mid-transfer: FSM returns to IDLE, pending ack/err is dropped, and all registers take their reset values on that edge.

Test Plan:
- Reset check: hold rst 2 cycles -> iack_o=0, ierr_o=0, xint=0. Reading 0x08 and 0x0C returns 32'hFFFF_FFFF. Reading 0x00 returns 0.
- Basic write/read: write 0x14=3, 0x10=1, wait 40 cycles after the enable-write ack, read 0x00 -> 10 (±1 per the documented enable edge). iack_o is high exactly one cycle, the cycle after the strobe is sampled.
- Carry: write mtime lo=32'hFFFF_FFFE, hi=0, prescale=0, enable -> after 2 increments hi=1, lo=0.
- Interrupt: mtimecmp={0,100}, ctrl=3, mtime=90, prescale=0 -> xint rises 11±1 cycles later. Writing mtimecmp hi=1 drops xint on the next cycle.
- Errors: read offset 0x18 -> ierr_o=1 for one cycle, iack_o=0, idat_o=0. Write with iaddr_i=BASE+2 -> ierr_o=1, no register change. Access at BASE+0x40 -> no ack and no err for 5 cycles.
- Byte lanes and collision: write 0x08 with isel_i=4'b0010, idat_i=32'hAABBCCDD -> mtimecmp lo=32'hFFFFCCFF. Write mtime lo=5 with all lanes while counting -> the following read returns at least 5, not the old value + 1.
